// File: rtl/spiking_sa_sequencer.sv
// Spiking systolic-array sequencer.
// Loads K beats of row spikes and column weights into per-row/per-column
// FIFOs, then replays them with a diagonal skew so that operand k reaches
// PE(i,j) at the same time. Afterwards it waits for the PE pipeline to drain
// and signals completion with a single-cycle done pulse.
module spiking_sa_sequencer #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int DEPTH = 8,
    parameter int KW    = $clog2(DEPTH + 1)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic [KW-1:0]   i_k_len,
    input  logic            i_ld_valid,
    output logic            o_ld_ready,
    output logic [ROWS-1:0] o_row_w_en,
    output logic [COLS-1:0] o_col_w_en,
    output logic [ROWS-1:0] o_row_r_en,
    output logic [COLS-1:0] o_col_r_en,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err
);

    localparam int MAXRC = (ROWS > COLS) ? ROWS : COLS;
    // Counter width covers DEPTH+max(ROWS,COLS) so FEED/DRAIN counts never wrap.
    localparam int CW = $clog2(DEPTH + MAXRC + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(ROWS + COLS - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_kNext;
    logic [KW-1:0] r_beatCnt;
    logic [KW-1:0] w_beatNext;
    logic [KW-1:0] w_beatInc;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cntNext;
    logic          r_err;
    logic          w_errNext;
    logic          w_kValid;
    logic          w_beat;
    logic [CW-1:0] w_kExt;
    logic [CW-1:0] w_feedLast;

    assign w_kExt     = CW'(r_k);
    // Last FEED count is K+max(ROWS,COLS)-2; modular arithmetic keeps this
    // correct even for a 1-wide array where the offset is -1.
    assign w_feedLast = w_kExt + CW'(MAXRC - 2);
    assign w_kValid   = (i_k_len != '0) && (i_k_len <= KW'(DEPTH));
    assign w_beat     = (r_state == S_LOAD) && i_ld_valid;
    assign w_beatInc  = r_beatCnt + KW'(1);

    // State, latched K, counters and the err pulse register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_beatCnt <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_k       <= w_kNext;
            r_beatCnt <= w_beatNext;
            r_cnt     <= w_cntNext;
            r_err     <= w_errNext;
        end
    end

    // Next-state and counter update; start is only looked at in IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_kNext     = r_k;
        w_beatNext  = r_beatCnt;
        w_cntNext   = r_cnt;
        w_errNext   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_kValid) begin
                        w_stateNext = S_LOAD;
                        w_kNext     = i_k_len;
                        w_beatNext  = '0;
                        w_cntNext   = '0;
                    end else begin
                        w_errNext = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (i_ld_valid) begin
                    w_beatNext = w_beatInc;
                    if (w_beatInc == r_k) begin
                        w_stateNext = S_FEED;
                        w_cntNext   = '0;
                    end
                end
            end
            S_FEED: begin
                if (r_cnt == w_feedLast) begin
                    w_stateNext = S_DRAIN;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_stateNext = S_DONE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Diagonal skew: lane n is read while n <= t < n+K during FEED.
    always_comb begin
        o_row_r_en = '0;
        o_col_r_en = '0;
        for (int i = 0; i < ROWS; i++) begin
            o_row_r_en[i] = (r_state == S_FEED) && (r_cnt >= CW'(i)) &&
                            (r_cnt < (CW'(i) + w_kExt));
        end
        for (int j = 0; j < COLS; j++) begin
            o_col_r_en[j] = (r_state == S_FEED) && (r_cnt >= CW'(j)) &&
                            (r_cnt < (CW'(j) + w_kExt));
        end
    end

    assign o_ld_ready = (r_state == S_LOAD);
    assign o_row_w_en = {ROWS{w_beat}};
    assign o_col_w_en = {COLS{w_beat}};
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_err      = r_err;

endmodule

// File: tb/tb_spiking_sa_sequencer.sv
// Self-checking bench for spiking_sa_sequencer: directed vector table,
// hand-written corner sequences, randomized passes against a schedule model,
// and a 3x2 instance with FIFO occupancy monitors.
module tb_spiking_sa_sequencer;

    localparam int DEPTH = 8;
    localparam int KW    = 4;
    localparam int AR    = 2;
    localparam int AC    = 2;
    localparam int BR    = 3;
    localparam int BC    = 2;
    localparam int AM    = (AR > AC) ? AR : AC;

    logic clk = 1'b0;
    logic rstn;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    logic          aStart, aValid, aReady, aBusy, aDone, aErr;
    logic [KW-1:0] aK;
    logic [AR-1:0] aRowW, aRowR;
    logic [AC-1:0] aColW, aColR;
    logic [11:0]   aOut;

    logic          bStart, bValid, bReady, bBusy, bDone, bErr;
    logic [KW-1:0] bK;
    logic [BR-1:0] bRowW, bRowR;
    logic [BC-1:0] bColW, bColR;
    logic [12:0]   bOut;

    assign aOut = {aReady, aRowW, aColW, aRowR, aColR, aBusy, aDone, aErr};
    assign bOut = {bReady, bRowW, bColW, bRowR, bColR, bBusy, bDone, bErr};

    spiking_sa_sequencer #(.ROWS(AR), .COLS(AC), .DEPTH(DEPTH), .KW(KW)) dutA (
        .i_clk(clk), .i_rstn(rstn), .i_start(aStart), .i_k_len(aK),
        .i_ld_valid(aValid), .o_ld_ready(aReady),
        .o_row_w_en(aRowW), .o_col_w_en(aColW),
        .o_row_r_en(aRowR), .o_col_r_en(aColR),
        .o_busy(aBusy), .o_done(aDone), .o_err(aErr)
    );

    spiking_sa_sequencer #(.ROWS(BR), .COLS(BC), .DEPTH(DEPTH), .KW(KW)) dutB (
        .i_clk(clk), .i_rstn(rstn), .i_start(bStart), .i_k_len(bK),
        .i_ld_valid(bValid), .o_ld_ready(bReady),
        .o_row_w_en(bRowW), .o_col_w_en(bColW),
        .o_row_r_en(bRowR), .o_col_r_en(bColR),
        .o_busy(bBusy), .o_done(bDone), .o_err(bErr)
    );

    int nChecks = 0;
    int nFails  = 0;

    // FIFO occupancy monitors: index 0..R-1 rows, R.. columns.
    int   aOcc [AR+AC];
    int   bOcc [BR+BC];
    logic aBad [AR+AC] = '{default: 1'b0};
    logic bBad [BR+BC] = '{default: 1'b0};

    // Track FIFO fill levels and flag reads when empty or writes when full.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < AR + AC; i++) aOcc[i] <= 0;
            for (int i = 0; i < BR + BC; i++) bOcc[i] <= 0;
        end else begin
            for (int i = 0; i < AR; i++) begin
                if ((aRowR[i] && aOcc[i] == 0) || (aRowW[i] && aOcc[i] == DEPTH)) aBad[i] <= 1'b1;
                aOcc[i] <= aOcc[i] + int'(aRowW[i]) - int'(aRowR[i]);
            end
            for (int j = 0; j < AC; j++) begin
                if ((aColR[j] && aOcc[AR+j] == 0) || (aColW[j] && aOcc[AR+j] == DEPTH)) aBad[AR+j] <= 1'b1;
                aOcc[AR+j] <= aOcc[AR+j] + int'(aColW[j]) - int'(aColR[j]);
            end
            for (int i = 0; i < BR; i++) begin
                if ((bRowR[i] && bOcc[i] == 0) || (bRowW[i] && bOcc[i] == DEPTH)) bBad[i] <= 1'b1;
                bOcc[i] <= bOcc[i] + int'(bRowW[i]) - int'(bRowR[i]);
            end
            for (int j = 0; j < BC; j++) begin
                if ((bColR[j] && bOcc[BR+j] == 0) || (bColW[j] && bOcc[BR+j] == DEPTH)) bBad[BR+j] <= 1'b1;
                bOcc[BR+j] <= bOcc[BR+j] + int'(bColW[j]) - int'(bColR[j]);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model for dutA: idle / loading / scheduled phases.
    int          mPhase;
    int          mK;
    int          mBeats;
    logic        mErr;
    logic [11:0] mSched[$];

    task automatic modelReset();
        mPhase = 0;
        mK     = 0;
        mBeats = 0;
        mErr   = 1'b0;
        mSched.delete();
    endtask

    // Expected outputs after the last beat: skewed feed window, drain, done.
    task automatic buildSchedule(input int k);
        logic [AR-1:0] r;
        logic [AC-1:0] c;
        for (int t = 0; t < k + AM - 1; t++) begin
            for (int i = 0; i < AR; i++) r[i] = (t >= i) && (t < i + k);
            for (int j = 0; j < AC; j++) c[j] = (t >= j) && (t < j + k);
            mSched.push_back({1'b0, 2'b00, 2'b00, r, c, 3'b100});
        end
        for (int d = 0; d < AR + AC - 1; d++) mSched.push_back(12'b0_00_00_00_00_100);
        mSched.push_back(12'b0_00_00_00_00_110);
    endtask

    // One clock cycle on dutA compared against the model.
    task automatic applyStimulus(input logic st, input logic [KW-1:0] k, input logic v, input string tag);
        logic [11:0] exp;
        @(posedge clk);
        #1;
        aStart = st;
        aK     = k;
        aValid = v;
        if (mPhase == 0)      exp = {11'b0, mErr};
        else if (mPhase == 1) exp = {1'b1, {2{v}}, {2{v}}, 4'b0000, 3'b100};
        else                  exp = mSched.pop_front();
        @(negedge clk);
        checkOutput(tag, 32'(aOut), 32'(exp));
        mErr = 1'b0;
        if (mPhase == 0) begin
            if (st) begin
                if (k >= 1 && k <= DEPTH) begin
                    mPhase = 1;
                    mK     = int'(k);
                    mBeats = 0;
                end else begin
                    mErr = 1'b1;
                end
            end
        end else if (mPhase == 1) begin
            if (v) begin
                mBeats++;
                if (mBeats == mK) begin
                    mPhase = 2;
                    buildSchedule(mK);
                end
            end
        end else if (mSched.size() == 0) begin
            mPhase = 0;
        end
    endtask

    task automatic runToIdle(input logic rnd, input string tag);
        int n;
        logic st;
        logic v;
        n = 0;
        while ((mPhase != 0 || mErr) && n < 200) begin
            st = rnd && (mPhase != 0) && ($urandom_range(0, 5) == 0);
            v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            applyStimulus(st, KW'($urandom_range(1, 8)), v, tag);
            n++;
        end
        if (n >= 200) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s budget: model still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    typedef struct {
        logic          st;
        logic [KW-1:0] k;
        logic          v;
        logic [11:0]   exp;
    } vec_t;

    vec_t tbl [18];
    int   busyCnt, feedCnt, doneCnt, wCnt, badCnt, occSum;
    int   rowCnt [BR];
    int   colCnt [BC];

    // Hard stop in case something never returns.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstn = 1'b0;
        aStart = 1'b0; aK = '0; aValid = 1'b0;
        bStart = 1'b0; bK = '0; bValid = 1'b0;
        modelReset();

        // Vector table: K=3 pass with ld_valid high, start ignored in DONE, bad k_len.
        tbl[0]  = '{1'b1, 4'd3, 1'b0, 12'b0_00_00_00_00_000};
        tbl[1]  = '{1'b0, 4'd0, 1'b1, 12'b1_11_11_00_00_100};
        tbl[2]  = '{1'b0, 4'd0, 1'b1, 12'b1_11_11_00_00_100};
        tbl[3]  = '{1'b0, 4'd0, 1'b1, 12'b1_11_11_00_00_100};
        tbl[4]  = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_01_01_100};
        tbl[5]  = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_11_11_100};
        tbl[6]  = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_11_11_100};
        tbl[7]  = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_10_10_100};
        tbl[8]  = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_00_00_100};
        tbl[9]  = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_00_00_100};
        tbl[10] = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_00_00_100};
        tbl[11] = '{1'b1, 4'd3, 1'b1, 12'b0_00_00_00_00_110};
        tbl[12] = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_00_00_000};
        tbl[13] = '{1'b1, 4'd0, 1'b0, 12'b0_00_00_00_00_000};
        tbl[14] = '{1'b1, 4'd9, 1'b0, 12'b0_00_00_00_00_001};
        tbl[15] = '{1'b0, 4'd0, 1'b0, 12'b0_00_00_00_00_001};
        tbl[16] = '{1'b0, 4'd0, 1'b1, 12'b0_00_00_00_00_000};
        tbl[17] = '{1'b0, 4'd0, 1'b0, 12'b0_00_00_00_00_000};

        #12;
        checkOutput("resetA", 32'(aOut), 32'd0);
        checkOutput("resetB", 32'(bOut), 32'd0);
        #10;
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(posedge clk);
            #1;
            aStart = tbl[i].st;
            aK     = tbl[i].k;
            aValid = tbl[i].v;
            @(negedge clk);
            checkOutput($sformatf("table[%0d]", i), 32'(aOut), 32'(tbl[i].exp));
        end

        // ld_valid toggling 1,0,1,0,1 during LOAD with K=3.
        applyStimulus(1'b1, 4'd3, 1'b0, "toggleStart");
        applyStimulus(1'b0, 4'd0, 1'b1, "toggle");
        applyStimulus(1'b0, 4'd0, 1'b0, "toggle");
        applyStimulus(1'b0, 4'd0, 1'b1, "toggle");
        applyStimulus(1'b0, 4'd0, 1'b0, "toggle");
        applyStimulus(1'b0, 4'd0, 1'b1, "toggle");
        runToIdle(1'b0, "toggleTail");

        // start pulses while busy must be ignored.
        applyStimulus(1'b1, 4'd4, 1'b1, "busyStart");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 1'b1, "busyLoad");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd2, 1'b1, "busyFeedStart");
        runToIdle(1'b0, "busyTail");

        // Reset dropped in FEED at t=2, then a K=1 pass.
        applyStimulus(1'b1, 4'd3, 1'b1, "rstStart");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'd0, 1'b1, "rstPre");
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rstAsyncA", 32'(aOut), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rstHeldA", 32'(aOut), 32'd0);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        modelReset();
        applyStimulus(1'b1, 4'd1, 1'b1, "postRstStart");
        runToIdle(1'b0, "postRst");

        // Randomized passes, including invalid k_len and stray starts.
        for (int p = 0; p < 40; p++) begin
            applyStimulus(1'b1, KW'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), "randStart");
            runToIdle(1'b1, "rand");
            if ($urandom_range(0, 2) == 0) applyStimulus(1'b0, 4'd0, 1'($urandom_range(0, 1)), "randGap");
        end

        // 3x2 array, K=DEPTH, ld_valid held high.
        busyCnt = 0; feedCnt = 0; doneCnt = 0; wCnt = 0;
        for (int i = 0; i < BR; i++) rowCnt[i] = 0;
        for (int j = 0; j < BC; j++) colCnt[j] = 0;
        @(posedge clk);
        #1;
        bStart = 1'b1;
        bK     = 4'd8;
        bValid = 1'b1;
        @(negedge clk);
        checkOutput("B_startIdle", 32'(bOut), 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            bStart = 1'b0;
            @(negedge clk);
            if (bBusy) busyCnt++;
            if (bDone) doneCnt++;
            if (bRowW == 3'b111 && bColW == 2'b11) wCnt++;
            if (bRowR != '0 || bColR != '0) feedCnt++;
            for (int i = 0; i < BR; i++) rowCnt[i] += int'(bRowR[i]);
            for (int j = 0; j < BC; j++) colCnt[j] += int'(bColR[j]);
        end
        checkOutput("B_busyCycles", 32'(busyCnt), 32'd23);
        checkOutput("B_feedCycles", 32'(feedCnt), 32'd10);
        checkOutput("B_doneCount",  32'(doneCnt), 32'd1);
        checkOutput("B_writeCycles", 32'(wCnt), 32'd8);
        for (int i = 0; i < BR; i++) checkOutput($sformatf("B_rowReads[%0d]", i), 32'(rowCnt[i]), 32'd8);
        for (int j = 0; j < BC; j++) checkOutput($sformatf("B_colReads[%0d]", j), 32'(colCnt[j]), 32'd8);

        // FIFO monitors: no overflow/underflow and everything written was read.
        badCnt = 0;
        occSum = 0;
        for (int i = 0; i < AR + AC; i++) begin
            badCnt += int'(aBad[i]);
            occSum += aOcc[i];
        end
        checkOutput("A_fifoFlags", 32'(badCnt), 32'd0);
        checkOutput("A_fifoOccupancy", 32'(occSum), 32'd0);
        badCnt = 0;
        occSum = 0;
        for (int i = 0; i < BR + BC; i++) begin
            badCnt += int'(bBad[i]);
            occSum += bOcc[i];
        end
        checkOutput("B_fifoFlags", 32'(badCnt), 32'd0);
        checkOutput("B_fifoOccupancy", 32'(occSum), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
